// File: rtl/nexys4_result_capture_if.sv
// Processor-board result bus, as seen between the MIMD wrapper and the
// result-capture block.
//   DataOut      result word
//   DataValid    level; a rising edge announces a new valid result
//   DataInvalid  level; a rising edge announces a new result flagged invalid
// master: the wrapper driving results; slave: the capture block.
interface nexys4_result_capture_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataValid;
  logic                  DataInvalid;

  modport master (output DataOut, output DataValid, output DataInvalid);
  modport slave  (input  DataOut, input  DataValid, input  DataInvalid);
endinterface

// File: rtl/nexys4_result_capture.sv
// Consumer end of the processor result bus on the Nexys4.
// Each rising edge of DataValid/DataInvalid captures {DataInvalid, DataOut}
// into a small FIFO.  A debounced NextButton pops the head entry and a
// debounced ClearButton flushes the FIFO and the sticky flags.
// Ports:
//   Clock, Reset        clock (rising edge), async active-high reset
//   proc                result bus (slave side)
//   NextButton          raw button, pop head entry
//   ClearButton         raw button, flush FIFO and sticky flags
//   Display             head data, 0 when empty
//   DisplayError        head error tag, 0 when empty
//   DisplayValid        FIFO non-empty
//   Count, Full, Empty  occupancy
//   Overflow            sticky: a push was dropped while full
//   ErrorSeen           sticky: an invalid result was captured
//   Status_Red          Overflow | ErrorSeen
//   Status_Green        DisplayValid & ~Status_Red
module nexys4_result_capture #(
  parameter int DATA_WIDTH      = 16,
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 32
) (
  input  logic                       Clock,
  input  logic                       Reset,
  nexys4_result_capture_if.slave     proc,
  input  logic                       NextButton,
  input  logic                       ClearButton,
  output logic [DATA_WIDTH-1:0]      Display,
  output logic                       DisplayError,
  output logic                       DisplayValid,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Overflow,
  output logic                       ErrorSeen,
  output logic                       Status_Red,
  output logic                       Status_Green
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_ARMING,
    DB_PRESSED,
    DB_RELEASING
  } db_state_t;

  // Reset asserts immediately but releases on a clock edge, so no flop sees
  // a deassertion close to its active edge.
  logic rst_meta_reg;
  logic rst_int_reg;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rst_meta_reg <= 1'b1;
      rst_int_reg  <= 1'b1;
    end else begin
      rst_meta_reg <= 1'b0;
      rst_int_reg  <= rst_meta_reg;
    end
  end

  // ---------------- button debouncers: [0]=Next, [1]=Clear ----------------
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {ClearButton, NextButton};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_debounce
      logic           sync1_reg;
      logic           sync2_reg;
      db_state_t      state_reg;
      db_state_t      state_next;
      logic [DBW-1:0] cnt_reg;
      logic [DBW-1:0] cnt_next;
      logic           pulse;

      always_ff @(posedge Clock or posedge rst_int_reg) begin
        if (rst_int_reg) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          state_reg <= DB_IDLE;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // cnt_reg holds the number of consecutive stable samples already seen
      // in ARMING/RELEASING; the sample that completes the run is the one
      // taken with cnt_reg == DEBOUNCE_CYCLES-1.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse      = 1'b0;
        case (state_reg)
          DB_IDLE: begin
            if (sync2_reg) begin
              state_next = DB_ARMING;
              cnt_next   = DBW'(1);
            end
          end
          DB_ARMING: begin
            if (!sync2_reg) begin
              state_next = DB_IDLE;
              cnt_next   = '0;
            end else if (cnt_reg >= DBW'(DEBOUNCE_CYCLES - 1)) begin
              state_next = DB_PRESSED;
              cnt_next   = '0;
              pulse      = 1'b1;
            end else begin
              cnt_next = cnt_reg + DBW'(1);
            end
          end
          DB_PRESSED: begin
            if (!sync2_reg) begin
              state_next = DB_RELEASING;
              cnt_next   = DBW'(1);
            end
          end
          DB_RELEASING: begin
            // A bounce back high returns to PRESSED without a second pulse.
            if (sync2_reg) begin
              state_next = DB_PRESSED;
              cnt_next   = '0;
            end else if (cnt_reg >= DBW'(DEBOUNCE_CYCLES - 1)) begin
              state_next = DB_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + DBW'(1);
            end
          end
          default: begin
            state_next = DB_IDLE;
            cnt_next   = '0;
          end
        endcase
      end

      assign btn_pulse[gi] = pulse;
    end
  endgenerate

  // ---------------- result capture FIFO ----------------
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [CNTW-1:0]     count_reg;
  logic                v_q_reg;
  logic                i_q_reg;
  logic                overflow_reg;
  logic                error_seen_reg;

  logic                push;
  logic [DATA_WIDTH:0] entry;
  logic                fifo_empty;
  logic                fifo_full;
  logic                do_clear;
  logic                do_pop;
  logic                do_push;
  logic                drop;
  logic [DATA_WIDTH:0] head;

  assign push       = (proc.DataValid & ~v_q_reg) | (proc.DataInvalid & ~i_q_reg);
  // A simultaneous valid+invalid edge collapses into one entry tagged invalid.
  assign entry      = {proc.DataInvalid, proc.DataOut};
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNTW'(DEPTH));

  // Clear overrides everything; a pop frees a slot for a same-cycle push
  // even when full, so that case is not an overflow.
  assign do_clear = btn_pulse[1];
  assign do_pop   = btn_pulse[0] & ~fifo_empty & ~do_clear;
  assign do_push  = push & (~fifo_full | do_pop) & ~do_clear;
  assign drop     = push & fifo_full & ~do_pop & ~do_clear;

  always_ff @(posedge Clock or posedge rst_int_reg) begin
    if (rst_int_reg) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      v_q_reg        <= 1'b0;
      i_q_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      error_seen_reg <= 1'b0;
    end else begin
      v_q_reg <= proc.DataValid;
      i_q_reg <= proc.DataInvalid;
      if (do_clear) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        count_reg      <= '0;
        overflow_reg   <= 1'b0;
        error_seen_reg <= 1'b0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (do_push && !do_pop)      count_reg <= count_reg + CNTW'(1);
        else if (do_pop && !do_push) count_reg <= count_reg - CNTW'(1);
        if (drop) overflow_reg <= 1'b1;
        if (do_push && entry[DATA_WIDTH]) error_seen_reg <= 1'b1;
      end
    end
  end

  // Storage carries no reset: stale words are never visible because the
  // head is gated by Empty.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr_reg] <= entry;
  end

  assign head = mem[rd_ptr_reg];

  assign Display      = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign DisplayError = fifo_empty ? 1'b0 : head[DATA_WIDTH];
  assign DisplayValid = ~fifo_empty;
  assign Count        = count_reg;
  assign Full         = fifo_full;
  assign Empty        = fifo_empty;
  assign Overflow     = overflow_reg;
  assign ErrorSeen    = error_seen_reg;
  assign Status_Red   = overflow_reg | error_seen_reg;
  assign Status_Green = ~fifo_empty & ~(overflow_reg | error_seen_reg);

endmodule

// File: tb/tb_nexys4_result_capture.sv
// Bench for nexys4_result_capture.  Stimulus queues each value that should
// later appear at the FIFO head; a monitor pops and compares whenever the
// DUT presents a new head entry.  Point checks cover occupancy and flags.
module tb_nexys4_result_capture;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        NextButton = 1'b0;
  logic        ClearButton = 1'b0;
  logic [15:0] Display;
  logic        DisplayError;
  logic        DisplayValid;
  logic [3:0]  Count;
  logic        Full;
  logic        Empty;
  logic        Overflow;
  logic        ErrorSeen;
  logic        Status_Red;
  logic        Status_Green;

  int assertions = 0;
  int failures   = 0;

  logic [16:0] exp_q[$];

  nexys4_result_capture_if #(.DATA_WIDTH(16)) bus ();

  nexys4_result_capture #(
    .DATA_WIDTH(16),
    .DEPTH(8),
    .DEBOUNCE_CYCLES(32)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .proc         (bus.slave),
    .NextButton   (NextButton),
    .ClearButton  (ClearButton),
    .Display      (Display),
    .DisplayError (DisplayError),
    .DisplayValid (DisplayValid),
    .Count        (Count),
    .Full         (Full),
    .Empty        (Empty),
    .Overflow     (Overflow),
    .ErrorSeen    (ErrorSeen),
    .Status_Red   (Status_Red),
    .Status_Green (Status_Green)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("check %s: %0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Press one button (0=Next, 1=Clear) for 'hold' cycles, then wait long
  // enough for the release to settle.
  task automatic press(input int which, input int hold);
    if (which == 0) NextButton = 1'b1; else ClearButton = 1'b1;
    cycles(hold);
    if (which == 0) NextButton = 1'b0; else ClearButton = 1'b0;
    cycles(45);
  endtask

  task automatic pulse_valid(input logic [15:0] value);
    bus.DataOut   = value;
    bus.DataValid = 1'b1;
    cycles(1);
    bus.DataValid = 1'b0;
    cycles(1);
  endtask

  // Monitor: a new head is presented when the FIFO turns non-empty or when
  // an entry leaves while it stays non-empty.
  initial begin
    logic        prev_valid;
    logic [3:0]  prev_count;
    logic [16:0] req;
    prev_valid = 1'b0;
    prev_count = '0;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prev_valid = 1'b0;
        prev_count = '0;
      end else begin
        if (DisplayValid && (!prev_valid || Count < prev_count)) begin
          assertions++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL head_unexpected: got err=%0b data=%h, required no new head",
                     DisplayError, Display);
          end else begin
            req = exp_q.pop_front();
            if ({DisplayError, Display} !== req) begin
              failures++;
              $display("FAIL head: got err=%0b data=%h, required err=%0b data=%h",
                       DisplayError, Display, req[16], req[15:0]);
            end else begin
              $display("head: err=%0b data=%h", DisplayError, Display);
            end
          end
        end
        prev_valid = DisplayValid;
        prev_count = Count;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge Clock);
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.DataOut     = '0;
    bus.DataValid   = 1'b0;
    bus.DataInvalid = 1'b0;

    // 1: reset
    cycles(1);
    Reset = 1'b1;
    cycles(2);
    Reset = 1'b0;
    cycles(3);
    check("reset_count", 32'(Count), 32'd0);
    check("reset_empty", 32'(Empty), 32'd1);
    check("reset_display", 32'(Display), 32'd0);
    check("reset_red", 32'(Status_Red), 32'd0);
    check("reset_green", 32'(Status_Green), 32'd0);

    // 2: held-high DataValid pushes exactly once
    bus.DataOut   = 16'h0005;
    bus.DataValid = 1'b1;
    exp_q.push_back({1'b0, 16'h0005});
    cycles(50);
    bus.DataValid = 1'b0;
    cycles(2);
    check("held_count", 32'(Count), 32'd1);
    check("held_display", 32'(Display), 32'h0005);
    check("held_green", 32'(Status_Green), 32'd1);

    press(1, 40);
    check("clear_count", 32'(Count), 32'd0);

    // 3: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back({1'b0, 16'(i)});
      pulse_valid(16'(i));
    end
    cycles(1);
    check("ovf_count", 32'(Count), 32'd8);
    check("ovf_full", 32'(Full), 32'd1);
    check("ovf_flag", 32'(Overflow), 32'd1);
    check("ovf_display", 32'(Display), 32'd1);
    check("ovf_red", 32'(Status_Red), 32'd1);

    // 4: glitches then a long hold -> one pop
    for (int g = 0; g < 3; g++) begin
      NextButton = 1'b1;
      cycles(5);
      NextButton = 1'b0;
      cycles(5);
    end
    press(0, 100);
    check("pop_count", 32'(Count), 32'd7);
    check("pop_display", 32'(Display), 32'd2);

    // 5: valid and invalid rising together
    bus.DataOut     = 16'hDEAD;
    bus.DataValid   = 1'b1;
    bus.DataInvalid = 1'b1;
    exp_q.push_back({1'b1, 16'hDEAD});
    cycles(2);
    bus.DataValid   = 1'b0;
    bus.DataInvalid = 1'b0;
    cycles(1);
    check("err_count", 32'(Count), 32'd8);
    check("err_seen", 32'(ErrorSeen), 32'd1);
    for (int p = 0; p < 7; p++) press(0, 40);
    check("err_head_count", 32'(Count), 32'd1);
    check("err_head_flag", 32'(DisplayError), 32'd1);

    // 6: clear pulse lands on the same edge as a DataValid rise.
    // Two synchroniser stages plus 32 stable samples put the pulse on the
    // 34th rising edge after the button goes high.
    ClearButton = 1'b1;
    repeat (33) @(posedge Clock);
    @(negedge Clock);
    bus.DataOut   = 16'hBEEF;
    bus.DataValid = 1'b1;
    cycles(2);
    bus.DataValid = 1'b0;
    ClearButton   = 1'b0;
    cycles(45);
    check("clrpush_count", 32'(Count), 32'd0);
    check("clrpush_empty", 32'(Empty), 32'd1);
    check("clrpush_ovf", 32'(Overflow), 32'd0);
    check("clrpush_errseen", 32'(ErrorSeen), 32'd0);

    // Reset while NextButton is mid-debounce; button released during reset.
    NextButton = 1'b1;
    cycles(10);
    Reset = 1'b1;
    cycles(2);
    NextButton = 1'b0;
    cycles(1);
    Reset = 1'b0;
    cycles(3);
    check("rst_mid_count", 32'(Count), 32'd0);
    check("rst_mid_red", 32'(Status_Red), 32'd0);
    exp_q.push_back({1'b0, 16'h0042});
    pulse_valid(16'h0042);
    cycles(100);
    check("no_stray_pop_count", 32'(Count), 32'd1);
    check("no_stray_pop_display", 32'(Display), 32'h0042);

    check("heads_outstanding", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
